fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch control FSM; it is the initiator side of the program-counter load interface.
- Reads memory at the current pc_addr and latches opcode/operand bytes.
- Drives the PC's en / pc_in / data inputs for every PC change, since the PC only holds or loads and never self-increments. Sequential advance is pc_addr+1; taken jumps load the operand.
- Hands decoded non-control instructions to the execute stage through a valid/done handshake.

Parameters:
DATA_W, 8, byte/address width (fixed at 8; other values unsupported).
MEM_LATENCY, 1, cycles from mem_rd to valid mem_rdata (legal 1..4).

Ports:
clock  in  1  system clock, posedge.
rst  in  1  asynchronous, active-low reset.
pc_addr  in  8  current PC value, registered by the program counter.
pc_en  out  1  PC enable; drives the PC's en.
pc_load  out  1  PC load select; drives the PC's pc_in.
pc_data  out  8  next PC value; drives the PC's data.
mem_rd  out  1  memory read strobe; address is pc_addr.
mem_rdata  in  8  memory read data.
ir  out  8  latched opcode.
operand  out  8  latched second byte (0 for 1-byte instrs).
instr_valid  out  1  instruction presented to execute.
exec_done  in  1  execute accepts/finishes current instruction.
zero_flag  in  1  ALU zero flag, sampled for JZ.
halted  out  1  HLT executed.

Behaviour:
- Reset (rst low, async): state=IDLE; ir=0, operand=0, wait counter=0.
  - All outputs 0 while in reset: pc_en, pc_load, mem_rd, instr_valid, halted, pc_data.
  - Reset mid-instruction abandons it with no PC write.
- States: IDLE, OP_REQ, OP_WAIT, OP_LAT, OPD_REQ, OPD_WAIT, OPD_LAT, ISSUE, HALT.
- Outputs decode from state (Moore), except pc_data in OPD_LAT, which uses mem_rdata.
- IDLE -> OP_REQ unconditionally, giving one idle cycle after reset release.
- OP_REQ: mem_rd=1 for exactly one cycle.
  - MEM_LATENCY=1: next state OP_LAT.
  - Otherwise OP_WAIT for MEM_LATENCY-1 cycles, counted by the wait counter.
- OP_LAT:
  - ir<=mem_rdata; operand<=0.
  - pc_en=1, pc_load=1, pc_data=pc_addr+1 (mod 256; 8'hFF wraps to 8'h00).
  - 2-byte opcode -> OPD_REQ. HLT -> HALT. Otherwise -> ISSUE.
- OPD_REQ / OPD_WAIT: same as the opcode phase, but read the new pc_addr (already advanced).
- OPD_LAT: operand<=mem_rdata, then:
  - JMP, or JZ with zero_flag=1: pc_data=mem_rdata, pc_en=pc_load=1, next OP_REQ. No instr_valid.
  - JZ with zero_flag=0: pc_data=pc_addr+1, next OP_REQ.
  - Other 2-byte opcodes: pc_data=pc_addr+1, next ISSUE.
- ISSUE:
  - instr_valid=1 with ir/operand stable.
  - Stay in ISSUE while exec_done=0. exec_done=1 sampled -> OP_REQ next cycle.
  - exec_done outside ISSUE is ignored.
- HALT: halted=1; all strobes 0; exits only on reset.
- zero_flag is sampled only in OPD_LAT of a JZ.
- A jump to its own address loops forever; this is legal.
- Throughput:
  - 1-byte instr with exec_done already high: 3 cycles (REQ, LAT, ISSUE), plus wait states.
  - Jumps: 4 cycles.

Decomposition:
- Package fetch_pkg holds:
  - State enum.
  - Opcode class constants on opcode[7:5]: NOP=000, ALU=001, LDI=010, LDST=011, JMP=100, JZ=101, RSV=110 (treated as NOP, issued), HLT=111.
  - Function is_two_byte(op): true for classes 010, 011, 100, 101.
- Optional sub-module fetch_wait_cnt: latency down-counter, load on REQ, done flag.
- Everything else lives in one module.

Test Plan:
- Reset release, MEM_LATENCY=1, mem[0]=8'h20 (ALU), exec_done tied 1:
  - mem_rd at cycle 1.
  - OP_LAT loads pc_data=8'h01.
  - instr_valid with ir=8'h20 at cycle 3.
  - Next mem_rd at pc_addr=1.
- mem[5]=8'h80 (JMP), mem[6]=8'h3C:
  - PC sequence 5 -> 6 -> 8'h3C.
  - instr_valid never asserted.
  - operand=8'h3C.
- JZ 8'hA0 at addr 10, operand 8'h50:
  - zero_flag=1 -> PC 8'h50.
  - zero_flag=0 -> PC 12.
- Wrap: PC=8'hFF holding 8'h40 (LDI), mem[0]=8'h77:
  - PC goes FF -> 00 -> 01.
  - ISSUE with ir=8'h40, operand=8'h77.
- Handshake + latency: MEM_LATENCY=3, exec_done held low 5 cycles:
  - mem_rdata captured exactly 3 cycles after mem_rd.
  - instr_valid stays high 6 cycles.
  - No PC write during ISSUE.
- HLT (8'hE0) sets halted=1 with no further mem_rd. rst pulsed low mid-OPD_WAIT clears all outputs immediately and fetch restarts via IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and opcode decode for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int DATA_W = 8;

    // Fetch FSM states.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OP_REQ,
        ST_OP_WAIT,
        ST_OP_LAT,
        ST_OPD_REQ,
        ST_OPD_WAIT,
        ST_OPD_LAT,
        ST_ISSUE,
        ST_HALT
    } state_e;

    // Opcode classes live in opcode[7:5].
    localparam logic [2:0] CLS_NOP  = 3'b000;
    localparam logic [2:0] CLS_ALU  = 3'b001;
    localparam logic [2:0] CLS_LDI  = 3'b010;
    localparam logic [2:0] CLS_LDST = 3'b011;
    localparam logic [2:0] CLS_JMP  = 3'b100;
    localparam logic [2:0] CLS_JZ   = 3'b101;
    localparam logic [2:0] CLS_RSV  = 3'b110;
    localparam logic [2:0] CLS_HLT  = 3'b111;

    // Instructions carrying an operand byte after the opcode.
    function automatic logic is_two_byte(input logic [DATA_W-1:0] op);
        return (op[7:5] == CLS_LDI) || (op[7:5] == CLS_LDST) ||
               (op[7:5] == CLS_JMP) || (op[7:5] == CLS_JZ);
    endfunction

endpackage

// File: rtl/fetch_wait_cnt.sv
// Memory-latency down-counter: loaded on each read request, done when the
// remaining wait states have elapsed.
module fetch_wait_cnt #(
    parameter int MEM_LATENCY = 1
) (
    input  logic clock,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    // A request is followed by MEM_LATENCY-1 wait cycles; the last of them
    // sees a count of zero.
    localparam logic [1:0] LOAD_VAL = (MEM_LATENCY > 1) ? 2'(MEM_LATENCY - 2) : 2'd0;

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next count: reload on request, step down while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM. Reads opcode and operand bytes at the
// externally held PC, drives every PC update (the PC never increments on its
// own), resolves JMP/JZ locally and hands other instructions to execute.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_addr,
    output logic              pc_en,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_data,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] operand,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              zero_flag,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_done;
    logic [DATA_W-1:0] pc_next;
    logic              jump_taken;

    assign pc_next    = pc_addr + 1'b1;
    assign jump_taken = (ir_q[7:5] == CLS_JMP) || ((ir_q[7:5] == CLS_JZ) && zero_flag);

    fetch_wait_cnt #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_wait_cnt (
        .clock  (clock),
        .rst    (rst),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .done_o (cnt_done)
    );

    // Next-state, latch updates and Moore outputs (pc_data in OPD_LAT follows mem_rdata).
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        ir_d        = ir_q;
        operand_d   = operand_q;
        pc_en       = 1'b0;
        pc_load     = 1'b0;
        pc_data     = '0;
        mem_rd      = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_OP_REQ;
            end
            ST_OP_REQ: begin
                mem_rd   = 1'b1;
                cnt_load = 1'b1;
                state_d  = (MEM_LATENCY == 1) ? ST_OP_LAT : ST_OP_WAIT;
            end
            ST_OP_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_done) state_d = ST_OP_LAT;
            end
            ST_OP_LAT: begin
                ir_d      = mem_rdata;
                operand_d = '0;
                pc_en     = 1'b1;
                pc_load   = 1'b1;
                pc_data   = pc_next;
                if (is_two_byte(mem_rdata))           state_d = ST_OPD_REQ;
                else if (mem_rdata[7:5] == CLS_HLT)   state_d = ST_HALT;
                else                                  state_d = ST_ISSUE;
            end
            ST_OPD_REQ: begin
                mem_rd   = 1'b1;
                cnt_load = 1'b1;
                state_d  = (MEM_LATENCY == 1) ? ST_OPD_LAT : ST_OPD_WAIT;
            end
            ST_OPD_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_done) state_d = ST_OPD_LAT;
            end
            ST_OPD_LAT: begin
                operand_d = mem_rdata;
                pc_en     = 1'b1;
                pc_load   = 1'b1;
                if (jump_taken) begin
                    pc_data = mem_rdata;
                    state_d = ST_OP_REQ;
                end else begin
                    pc_data = pc_next;
                    // A not-taken JZ simply falls through; nothing to execute.
                    state_d = (ir_q[7:5] == CLS_JZ) ? ST_OP_REQ : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (exec_done) state_d = ST_OP_REQ;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and instruction registers; reset abandons any fetch in flight.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            operand_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
        end
    end

    assign ir      = ir_q;
    assign operand = operand_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (read latency 1 and 3), each with a
// program-counter model and a latency-accurate memory model.
module tb_fetch_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Instance A: MEM_LATENCY = 1 ----------------
    logic       rst_a = 1'b0, pcr_a = 1'b0;
    logic [7:0] pc_a, pc_start_a = 8'h00;
    logic       pc_en_a, pc_load_a, mem_rd_a, valid_a, halted_a;
    logic [7:0] pc_data_a, rdata_a, ir_a, opd_a;
    logic       done_a = 1'b1, zf_a = 1'b0;
    logic [7:0] mem_a [256];
    logic [7:0] ma_addr = 8'h00;
    logic       ma_vld = 1'b0;

    fetch_sequencer #(.DATA_W(8), .MEM_LATENCY(1)) dut_a (
        .clock(clock), .rst(rst_a), .pc_addr(pc_a), .pc_en(pc_en_a), .pc_load(pc_load_a),
        .pc_data(pc_data_a), .mem_rd(mem_rd_a), .mem_rdata(rdata_a), .ir(ir_a),
        .operand(opd_a), .instr_valid(valid_a), .exec_done(done_a), .zero_flag(zf_a),
        .halted(halted_a)
    );

    // PC model: hold or load, with its own reset so DUT reset cannot move it.
    always @(posedge clock or negedge pcr_a) begin
        if (!pcr_a)                       pc_a <= pc_start_a;
        else if (pc_en_a && pc_load_a)    pc_a <= pc_data_a;
    end

    // Memory model: data for a read appears one cycle after the strobe.
    always @(posedge clock) begin
        ma_addr <= pc_a;
        ma_vld  <= mem_rd_a;
    end
    assign rdata_a = ma_vld ? mem_a[ma_addr] : 8'hEE;

    // ---------------- Instance B: MEM_LATENCY = 3 ----------------
    logic       rst_b = 1'b0, pcr_b = 1'b0;
    logic [7:0] pc_b, pc_start_b = 8'h00;
    logic       pc_en_b, pc_load_b, mem_rd_b, valid_b, halted_b;
    logic [7:0] pc_data_b, rdata_b, ir_b, opd_b;
    logic       done_b = 1'b1, zf_b = 1'b0;
    logic [7:0] mem_b [256];
    logic [7:0] mb_addr [3];
    logic       mb_vld [3];

    fetch_sequencer #(.DATA_W(8), .MEM_LATENCY(3)) dut_b (
        .clock(clock), .rst(rst_b), .pc_addr(pc_b), .pc_en(pc_en_b), .pc_load(pc_load_b),
        .pc_data(pc_data_b), .mem_rd(mem_rd_b), .mem_rdata(rdata_b), .ir(ir_b),
        .operand(opd_b), .instr_valid(valid_b), .exec_done(done_b), .zero_flag(zf_b),
        .halted(halted_b)
    );

    always @(posedge clock or negedge pcr_b) begin
        if (!pcr_b)                       pc_b <= pc_start_b;
        else if (pc_en_b && pc_load_b)    pc_b <= pc_data_b;
    end

    // Three-stage read pipeline: data valid exactly three cycles after the strobe.
    initial begin
        for (int i = 0; i < 3; i++) begin
            mb_addr[i] = 8'h00;
            mb_vld[i]  = 1'b0;
        end
    end
    always @(posedge clock) begin
        mb_addr[0] <= pc_b;      mb_vld[0] <= mem_rd_b;
        mb_addr[1] <= mb_addr[0]; mb_vld[1] <= mb_vld[0];
        mb_addr[2] <= mb_addr[1]; mb_vld[2] <= mb_vld[1];
    end
    assign rdata_b = mb_vld[2] ? mem_b[mb_addr[2]] : 8'hEE;

    // ---------------- Issue scoreboard for instance A ----------------
    typedef struct packed {
        logic [7:0] ir;
        logic [7:0] opd;
    } iss_t;

    iss_t sb_q[$];
    iss_t sb_e;
    logic mon_en = 1'b0;
    logic valid_prev_a = 1'b0;

    always @(negedge clock) begin
        if (mon_en && valid_a && !valid_prev_a) begin
            check("issue expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                sb_e = sb_q.pop_front();
                check("issue ir", 32'(ir_a), 32'(sb_e.ir));
                check("issue operand", 32'(opd_a), 32'(sb_e.opd));
            end
        end
        valid_prev_a = valid_a;
    end

    // ---------------- Vector table (instance A) ----------------
    typedef struct {
        string      name;
        logic [7:0] start;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       zf;
        int         len;
        logic [7:0] next_pc;
        logic       issue;
        logic [7:0] exp_opd;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v, input bit timing);
        logic [7:0] a1;
        int reads, vcnt, first_rd, first_w, first_v, next_cyc;
        logic [7:0] first_wd, opd_pc, next_pc;
        bit got;

        // NOTE: bench stimulus uses blocking assignments from procedural code.
        rst_a = 1'b0;
        pcr_a = 1'b0;
        pc_start_a = v.start;
        for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
        a1 = v.start + 8'd1;
        mem_a[v.start] = v.b0;
        mem_a[a1]      = v.b1;
        zf_a = v.zf;
        if (v.issue) sb_q.push_back('{ir: v.b0, opd: v.exp_opd});
        @(negedge clock);
        pcr_a = 1'b1;
        @(negedge clock);
        check({v.name, " reset outputs"},
              32'({pc_en_a, pc_load_a, mem_rd_a, valid_a, halted_a, pc_data_a, ir_a, opd_a}), 32'd0);
        rst_a  = 1'b1;
        mon_en = 1'b1;

        reads = 0; vcnt = 0; first_rd = -1; first_w = -1; first_v = -1; next_cyc = -1;
        first_wd = 8'h00; opd_pc = 8'h00; next_pc = 8'h00; got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clock);
            if (valid_a) begin
                vcnt++;
                if (first_v < 0) first_v = c;
            end
            if (pc_en_a && pc_load_a && first_w < 0) begin
                first_w  = c;
                first_wd = pc_data_a;
            end
            if (mem_rd_a) begin
                if (first_rd < 0) first_rd = c;
                if (reads == 1) opd_pc = pc_a;
                if (reads == v.len) begin
                    got = 1'b1;
                    next_pc = pc_a;
                    next_cyc = c;
                end
                reads++;
            end
        end
        mon_en = 1'b0;

        check({v.name, " next fetch seen"}, 32'(got), 32'd1);
        check({v.name, " next pc"}, 32'(next_pc), 32'(v.next_pc));
        check({v.name, " valid cycles"}, 32'(vcnt), 32'(v.issue));
        check({v.name, " ir"}, 32'(ir_a), 32'(v.b0));
        check({v.name, " operand"}, 32'(opd_a), 32'(v.exp_opd));
        if (v.len == 2) check({v.name, " operand addr"}, 32'(opd_pc), 32'(a1));
        if (timing) begin
            check("t first mem_rd cycle", 32'(first_rd), 32'd1);
            check("t first pc write cycle", 32'(first_w), 32'd2);
            check("t first pc_data", 32'(first_wd), 32'h01);
            check("t instr_valid cycle", 32'(first_v), 32'd3);
            check("t next fetch cycle", 32'(next_cyc), 32'd4);
        end
    endtask

    // ---------------- Instance B helpers ----------------
    task automatic reset_b(input logic [7:0] start);
        rst_b = 1'b0;
        pcr_b = 1'b0;
        pc_start_b = start;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
        @(negedge clock);
        pcr_b = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"alu",      8'h00, 8'h20, 8'h00, 1'b0, 1, 8'h01, 1'b1, 8'h00};
        vecs[1] = '{"jmp",      8'h05, 8'h80, 8'h3C, 1'b0, 2, 8'h3C, 1'b0, 8'h3C};
        vecs[2] = '{"jz taken", 8'h0A, 8'hA0, 8'h50, 1'b1, 2, 8'h50, 1'b0, 8'h50};
        vecs[3] = '{"jz fall",  8'h0A, 8'hA0, 8'h50, 1'b0, 2, 8'h0C, 1'b0, 8'h50};
        vecs[4] = '{"ldi wrap", 8'hFF, 8'h40, 8'h77, 1'b0, 2, 8'h01, 1'b1, 8'h77};
        vecs[5] = '{"rsv",      8'h07, 8'hC5, 8'h00, 1'b1, 1, 8'h08, 1'b1, 8'h00};
        vecs[6] = '{"ldst",     8'h30, 8'h61, 8'h9A, 1'b1, 2, 8'h32, 1'b1, 8'h9A};
        vecs[7] = '{"nop",      8'hFE, 8'h00, 8'h00, 1'b0, 1, 8'hFF, 1'b1, 8'h00};
        vecs[8] = '{"jmp self", 8'hFF, 8'h80, 8'hFF, 1'b0, 2, 8'hFF, 1'b0, 8'hFF};

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i == 0);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        rst_a = 1'b0;

        // ---- Latency 3, LDI with a 6-cycle execute handshake ----
        begin
            int reads, wcnt, vcnt, pcw_issue;
            int rd_c [2];
            int w_c  [2];
            logic [7:0] next_pc;
            reset_b(8'h14);
            mem_b[8'h14] = 8'h41;
            mem_b[8'h15] = 8'h99;
            done_b = 1'b1;
            @(negedge clock);
            check("b reset outputs",
                  32'({pc_en_b, pc_load_b, mem_rd_b, valid_b, halted_b, pc_data_b, ir_b, opd_b}), 32'd0);
            rst_b = 1'b1;
            reads = 0; wcnt = 0; vcnt = 0; pcw_issue = 0; next_pc = 8'h00;
            rd_c[0] = -1; rd_c[1] = -1; w_c[0] = -1; w_c[1] = -1;
            for (int c = 1; c <= 60 && reads < 3; c++) begin
                @(negedge clock);
                if (mem_rd_b) begin
                    if (reads < 2) rd_c[reads] = c;
                    else           next_pc = pc_b;
                    reads++;
                end
                if (pc_en_b) begin
                    if (wcnt < 2) w_c[wcnt] = c;
                    wcnt++;
                    if (wcnt == 2) done_b = 1'b0;
                end
                if (valid_b) begin
                    vcnt++;
                    if (pc_en_b) pcw_issue++;
                    if (vcnt == 6) done_b = 1'b1;
                end
            end
            check("b first mem_rd cycle", 32'(rd_c[0]), 32'd1);
            check("b opcode latency", 32'(w_c[0] - rd_c[0]), 32'd3);
            check("b operand latency", 32'(w_c[1] - rd_c[1]), 32'd3);
            check("b valid cycles", 32'(vcnt), 32'd6);
            check("b pc write in issue", 32'(pcw_issue), 32'd0);
            check("b ir", 32'(ir_b), 32'h41);
            check("b operand", 32'(opd_b), 32'h99);
            check("b next pc", 32'(next_pc), 32'h16);
        end

        // ---- HLT stops fetching ----
        begin
            int reads;
            reset_b(8'h00);
            mem_b[8'h00] = 8'hE0;
            @(negedge clock);
            rst_b = 1'b1;
            reads = 0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clock);
                if (mem_rd_b) reads++;
            end
            check("hlt reads", 32'(reads), 32'd1);
            check("hlt halted", 32'(halted_b), 32'd1);
            check("hlt pc", 32'(pc_b), 32'h01);
            check("hlt valid", 32'(valid_b), 32'd0);
        end

        // ---- Reset during the operand wait abandons the jump ----
        begin
            int reads, first_rd;
            logic [7:0] rd_pc;
            reset_b(8'h28);
            mem_b[8'h28] = 8'h80;
            mem_b[8'h29] = 8'h3C;
            @(negedge clock);
            rst_b = 1'b1;
            reads = 0;
            for (int c = 1; c <= 30 && reads < 2; c++) begin
                @(negedge clock);
                if (mem_rd_b) reads++;
            end
            check("mid reads before reset", 32'(reads), 32'd2);
            @(negedge clock);
            rst_b = 1'b0;
            #1;
            check("mid reset outputs",
                  32'({pc_en_b, pc_load_b, mem_rd_b, valid_b, halted_b, pc_data_b, ir_b, opd_b}), 32'd0);
            repeat (4) @(negedge clock);
            check("mid pc unchanged", 32'(pc_b), 32'h29);
            rst_b = 1'b1;
            first_rd = -1;
            rd_pc = 8'h00;
            for (int c = 1; c <= 10 && first_rd < 0; c++) begin
                @(negedge clock);
                if (mem_rd_b) begin
                    first_rd = c;
                    rd_pc = pc_b;
                end
            end
            check("restart mem_rd cycle", 32'(first_rd), 32'd1);
            check("restart pc", 32'(rd_pc), 32'h29);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
